// File: rtl/nanov_spi_ram_pkg.sv
// Shared definitions for the nanoV SPI SRAM responder.
//
// Contents:
//   OP_READ, OP_WRITE, OP_FAST_READ  opcodes recognised by the responder
//   ADDR_BITS                        width of the serial address field
//   spi_state_t                      responder FSM states
//
// Optional feature macro used by the files that import this package:
//   SPI_RAM_FAST_READ_EN  enables the FAST READ (0x0B) opcode with 8 dummy bits
package nanoV_spi_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_WRITE     = 8'h02;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  localparam int ADDR_BITS = 24;

  typedef enum logic [2:0] {
    CMD,
    ADDR,
    DUMMY,
    READ,
    WRITE,
    IGNORE
  } spi_state_t;

endpackage

// File: rtl/nanov_spi_ram_shifter.sv
// nanoV_spi_shifter: 8-bit shift register and 5-bit bit counter shared by all
// phases of the SPI responder (opcode, address, dummy and data bytes).
//
// Ports:
//   clk, rstn   clock and asynchronous active-low reset
//   clear       synchronous clear of counter and shift data (deselect)
//   shift_en    one bit event: shift bit_in in, advance the counter
//   bit_in      serial input bit (MOSI)
//   restart     on a bit event, return the counter to 0 instead of advancing
//   load_en     on a bit event, replace the shift data with load_data
//   load_data   parallel byte to present on the serial output
//   data_msb    bit 7 of the shift data (serial output bit)
//   next_byte   byte that the shift data becomes if bit_in is shifted in now
//   byte_done   bit event that completes a byte (counter low bits == 7)
//   word_done   bit event that completes the 24-bit address field
//
// Optional feature macro: none in this file (SPI_RAM_FAST_READ_EN is handled
// by the top module).
module nanoV_spi_shifter
  import nanoV_spi_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       bit_in,
  input  logic       restart,
  input  logic       load_en,
  input  logic [7:0] load_data,
  output logic       data_msb,
  output logic [7:0] next_byte,
  output logic       byte_done,
  output logic       word_done
);

  logic [7:0] data;
  logic [4:0] bit_cnt;

  // The strobes are qualified by shift_en so that the top can act on them
  // directly as "this edge completes a byte / the address".
  assign data_msb  = data[7];
  assign next_byte = {data[6:0], bit_in};
  assign byte_done = shift_en && (bit_cnt[2:0] == 3'd7);
  assign word_done = shift_en && (bit_cnt == 5'(ADDR_BITS - 1));

  // Shift data and bit counter. A parallel load takes priority over the shift
  // so the next read byte lands on the same edge that finishes the previous
  // one; restart lets the owner reset the count at every phase boundary.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data    <= 8'h00;
      bit_cnt <= 5'd0;
    end else if (clear) begin
      data    <= 8'h00;
      bit_cnt <= 5'd0;
    end else if (shift_en) begin
      data    <= load_en ? load_data : next_byte;
      bit_cnt <= restart ? 5'd0 : bit_cnt + 5'd1;
    end
  end

endmodule

// File: rtl/nanov_spi_ram.sv
// nanov_spi_ram: cycle-accurate 23LC-style SPI SRAM responder for the nanoV CPU.
// Supports sequential READ (0x03) and WRITE (0x02) with a 24-bit address, of
// which only the low log2(DEPTH) bits are used. Zero dummy bits on READ.
//
// Parameters:
//   DEPTH      memory size in bytes (power of 2)
//   INIT_FILE  optional preload image name; memory is preloaded through the
//              backdoor port
//
// Ports:
//   clk             system clock shared with the CPU
//   rstn            asynchronous active-low reset
//   spi_select      chip select, active-low
//   spi_mosi        serial data in, MSB first
//   spi_clk_enable  bit-transfer qualifier
//   spi_miso        serial data out (0 whenever not streaming read data)
//   ld_en           backdoor byte write strobe
//   ld_addr         backdoor byte address
//   ld_data         backdoor byte data
//
// Optional feature macro:
//   SPI_RAM_FAST_READ_EN  accept FAST READ (0x0B): 8 dummy bits after the
//                         address, then the READ stream. Without it 0x0B is
//                         treated as an unknown opcode.
module nanov_spi_ram
  import nanoV_spi_pkg::*;
#(
  parameter int    DEPTH     = 256,
  parameter string INIT_FILE = "",
  localparam int   AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          spi_select,
  input  logic          spi_mosi,
  input  logic          spi_clk_enable,
  output logic          spi_miso,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data
);

  logic [7:0]    mem [DEPTH];
  spi_state_t    state;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr_next;
  logic          rd_flag;
`ifdef SPI_RAM_FAST_READ_EN
  logic          fast_flag;
`endif

  logic          shift_en;
  logic          restart;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [7:0]    load_data;
  logic          shift_msb;
  logic [7:0]    next_byte;
  logic          byte_done;
  logic          word_done;

  // The address is shifted in bit by bit; keeping only the low AW bits means
  // the upper address bits fall off the top and are ignored automatically.
  assign shift_en  = !spi_select && spi_clk_enable;
  assign addr_next = AW'({addr, spi_mosi});
  assign restart   = (state == ADDR) ? word_done : byte_done;
  assign load_data = mem[load_addr];
  assign spi_miso  = !spi_select && (state == READ) && shift_msb;

  nanoV_spi_shifter u_shifter (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (spi_select),
    .shift_en  (shift_en),
    .bit_in    (spi_mosi),
    .restart   (restart),
    .load_en   (load_en),
    .load_data (load_data),
    .data_msb  (shift_msb),
    .next_byte (next_byte),
    .byte_done (byte_done),
    .word_done (word_done)
  );

  // Choose which byte, if any, is loaded into the output shifter on this
  // edge: the first byte on the last address bit (or last dummy bit), and
  // the following byte on the last bit of each streamed byte.
  always_comb begin
    load_en   = 1'b0;
    load_addr = addr;
    case (state)
      ADDR: begin
        load_addr = addr_next;
`ifdef SPI_RAM_FAST_READ_EN
        load_en   = word_done && rd_flag && !fast_flag;
`else
        load_en   = word_done && rd_flag;
`endif
      end
      DUMMY: begin
        load_en = byte_done;
      end
      READ: begin
        load_addr = addr + AW'(1);
        load_en   = byte_done;
      end
      default: begin
        load_en = 1'b0;
      end
    endcase
  end

  // Transaction FSM. Deselect returns to CMD from any state; with the clock
  // enable low everything holds. The address register accumulates during
  // ADDR and then serves as the byte pointer for the data phase.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= CMD;
      addr      <= '0;
      rd_flag   <= 1'b0;
`ifdef SPI_RAM_FAST_READ_EN
      fast_flag <= 1'b0;
`endif
    end else if (spi_select) begin
      state <= CMD;
    end else if (spi_clk_enable) begin
      case (state)
        CMD: begin
          if (byte_done) begin
            case (next_byte)
              OP_READ: begin
                state     <= ADDR;
                rd_flag   <= 1'b1;
`ifdef SPI_RAM_FAST_READ_EN
                fast_flag <= 1'b0;
`endif
              end
              OP_WRITE: begin
                state     <= ADDR;
                rd_flag   <= 1'b0;
`ifdef SPI_RAM_FAST_READ_EN
                fast_flag <= 1'b0;
`endif
              end
`ifdef SPI_RAM_FAST_READ_EN
              OP_FAST_READ: begin
                state     <= ADDR;
                rd_flag   <= 1'b1;
                fast_flag <= 1'b1;
              end
`endif
              default: state <= IGNORE;
            endcase
          end
        end
        ADDR: begin
          addr <= addr_next;
          if (word_done) begin
            if (!rd_flag) begin
              state <= WRITE;
`ifdef SPI_RAM_FAST_READ_EN
            end else if (fast_flag) begin
              state <= DUMMY;
`endif
            end else begin
              state <= READ;
            end
          end
        end
        DUMMY: begin
          if (byte_done) state <= READ;
        end
        READ, WRITE: begin
          if (byte_done) addr <= addr + AW'(1);
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

  // Memory write port. The backdoor assignment comes last so that it wins
  // over an SPI byte commit to the same address on the same edge. The array
  // is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if ((state == WRITE) && byte_done) mem[addr] <= next_byte;
    if (ld_en) mem[ld_addr] <= ld_data;
  end

endmodule

// File: tb/tb_nanov_spi_ram.sv
// Self-checking bench for nanov_spi_ram (DEPTH=256). A byte-array model of
// the SRAM is updated from the bench's own view of every write; every read
// is compared against it. Inputs change on the falling edge, MISO is sampled
// just after, i.e. the value the CPU would capture on the next rising edge.
module tb_nanov_spi_ram;

  logic       clk = 1'b0;
  logic       rstn;
  logic       spi_select;
  logic       spi_mosi;
  logic       spi_clk_enable;
  logic       spi_miso;
  logic       ld_en;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;

  logic [7:0] model [256];
  int         checks = 0;
  int         fails  = 0;
  bit         rand_stall = 1'b0;

  nanov_spi_ram #(.DEPTH(256), .INIT_FILE("")) dut (
    .clk            (clk),
    .rstn           (rstn),
    .spi_select     (spi_select),
    .spi_mosi       (spi_mosi),
    .spi_clk_enable (spi_clk_enable),
    .spi_miso       (spi_miso),
    .ld_en          (ld_en),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One SPI bit event, optionally preceded by random clock-enable stalls.
  task automatic spiBit(input logic b, output logic m);
    if (rand_stall && ($urandom_range(0, 3) == 0)) begin
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        spi_select = 1'b0;
        spi_clk_enable = 1'b0;
        spi_mosi = 1'($urandom);
        @(posedge clk);
      end
    end
    @(negedge clk);
    spi_select = 1'b0;
    spi_clk_enable = 1'b1;
    spi_mosi = b;
    #1 m = spi_miso;
    @(posedge clk);
  endtask

  task automatic sendByte(input logic [7:0] b);
    logic m;
    for (int i = 7; i >= 0; i--) spiBit(b[i], m);
  endtask

  task automatic readByte(output logic [7:0] r);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      spiBit(1'($urandom), m);
      r[i] = m;
    end
  endtask

  task automatic sendCmd(input logic [7:0] op, input logic [23:0] a);
    sendByte(op);
    sendByte(a[23:16]);
    sendByte(a[15:8]);
    sendByte(a[7:0]);
  endtask

  task automatic deselect();
    @(negedge clk);
    spi_select = 1'b1;
    spi_clk_enable = 1'($urandom);
    #1 checkOutput("desel_miso", {31'd0, spi_miso}, 32'd0);
    @(posedge clk);
  endtask

  task automatic backdoor(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    spi_clk_enable = 1'b0;
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
    model[a] = d;
  endtask

  // SPI write of n bytes; the model follows with address wrap.
  task automatic writeBlock(input logic [23:0] a, input int n);
    logic [7:0] d;
    sendCmd(8'h02, a);
    for (int k = 0; k < n; k++) begin
      d = 8'($urandom);
      sendByte(d);
      model[(int'(a[7:0]) + k) % 256] = d;
    end
    deselect();
  endtask

  task automatic checkRead(input string tag, input logic [23:0] a, input int n);
    logic [7:0] r;
    sendCmd(8'h03, a);
    for (int k = 0; k < n; k++) begin
      readByte(r);
      checkOutput(tag, {24'd0, r}, {24'd0, model[(int'(a[7:0]) + k) % 256]});
    end
    deselect();
  endtask

  // One random transaction: backdoor write, SPI write, or SPI read.
  task automatic applyStimulus();
    int op;
    logic [23:0] a;
    op = $urandom_range(0, 2);
    a = 24'($urandom);
    case (op)
      0: backdoor(a[7:0], 8'($urandom));
      1: writeBlock(a, $urandom_range(1, 4));
      default: checkRead("rand_read", a, $urandom_range(1, 4));
    endcase
  endtask

  initial begin
    logic [31:0] word;
    logic [31:0] exp_word;
    logic [7:0]  r;
    logic        m;

    rstn = 1'b0;
    spi_select = 1'b0;
    spi_mosi = 1'b0;
    spi_clk_enable = 1'b0;
    ld_en = 1'b0;
    ld_addr = 8'h00;
    ld_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 checkOutput("reset_miso", {31'd0, spi_miso}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    spi_select = 1'b1;

    // Known random contents everywhere, then the test plan pattern
    for (int i = 0; i < 256; i++) backdoor(8'(i), 8'($urandom));
    backdoor(8'h10, 8'hDE);
    backdoor(8'h11, 8'hAD);
    backdoor(8'h12, 8'hBE);
    backdoor(8'h13, 8'hEF);

    // Basic read with zero latency
    sendCmd(8'h03, 24'h000010);
    word = '0;
    for (int i = 31; i >= 0; i--) begin
      spiBit(1'b0, m);
      word[i] = m;
    end
    checkOutput("read_deadbeef", word, 32'hDEADBEEF);
    deselect();

    // Write two bytes, read back three
    sendCmd(8'h02, 24'h000020);
    sendByte(8'hA5);
    sendByte(8'h5A);
    model[8'h20] = 8'hA5;
    model[8'h21] = 8'h5A;
    deselect();
    checkRead("write_readback", 24'h000020, 3);

    // Address wrap, upper address bits ignored
    checkRead("wrap_ff", 24'h0000FF, 2);
    checkRead("wrap_hi_bits", 24'h0123FF, 2);

    // Partial write byte is discarded, next command decodes
    sendCmd(8'h02, 24'h000030);
    for (int i = 0; i < 4; i++) spiBit(1'(i % 2), m);
    deselect();
    checkRead("partial_write", 24'h000030, 1);

    // Clock-enable stall mid-read
    exp_word = {model[8'h10], model[8'h11], model[8'h12], model[8'h13]};
    sendCmd(8'h03, 24'h000010);
    word = '0;
    for (int i = 31; i >= 20; i--) begin
      spiBit(1'b0, m);
      word[i] = m;
    end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      spi_clk_enable = 1'b0;
      spi_mosi = 1'($urandom);
      #1 checkOutput("stall_hold", {31'd0, spi_miso}, {31'd0, exp_word[19]});
      @(posedge clk);
    end
    for (int i = 19; i >= 0; i--) begin
      spiBit(1'b0, m);
      word[i] = m;
    end
    checkOutput("stall_stream", word, exp_word);
    deselect();

    // Reset while streaming a 1 bit forces MISO low at once
    sendCmd(8'h03, 24'h000010);
    @(negedge clk);
    spi_clk_enable = 1'b0;
    #1 checkOutput("pre_rst_miso", {31'd0, spi_miso}, 32'd1);
    rstn = 1'b0;
    #1 checkOutput("rst_read_miso", {31'd0, spi_miso}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    deselect();

    // Reset mid-ADDR, then a new command without deselect
    sendByte(8'h03);
    sendByte(8'h00);
    sendByte(8'h00);
    @(negedge clk);
    spi_clk_enable = 1'b0;
    rstn = 1'b0;
    #1 checkOutput("rst_addr_miso", {31'd0, spi_miso}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    sendCmd(8'h03, 24'h000010);
    readByte(r);
    checkOutput("after_rst_read", {24'd0, r}, {24'd0, model[8'h10]});
    deselect();

    // Backdoor wins against a simultaneous SPI commit
    sendCmd(8'h02, 24'h000040);
    for (int i = 7; i >= 1; i--) spiBit(1'b1, m);
    @(negedge clk);
    spi_clk_enable = 1'b1;
    spi_mosi = 1'b1;
    ld_en = 1'b1;
    ld_addr = 8'h40;
    ld_data = 8'h77;
    @(posedge clk);
    #1 ld_en = 1'b0;
    model[8'h40] = 8'h77;
    deselect();
    checkRead("backdoor_wins", 24'h000040, 1);

    // Unknown opcode keeps MISO low
    sendByte(8'h55);
    word = '0;
    for (int i = 31; i >= 0; i--) begin
      spiBit(1'($urandom), m);
      word[i] = m;
    end
    checkOutput("ignore_55", word, 32'd0);
    deselect();

`ifdef SPI_RAM_FAST_READ_EN
    sendCmd(8'h0B, 24'h000010);
    readByte(r);
    checkOutput("fast_dummy", {24'd0, r}, 32'd0);
    readByte(r);
    checkOutput("fast_data", {24'd0, r}, {24'd0, model[8'h10]});
    deselect();
`else
    sendByte(8'h0B);
    word = '0;
    for (int i = 31; i >= 0; i--) begin
      spiBit(1'b0, m);
      word[i] = m;
    end
    checkOutput("ignore_0B", word, 32'd0);
    deselect();
`endif

    // Randomized traffic with clock-enable stalls
    rand_stall = 1'b1;
    for (int t = 0; t < 60; t++) applyStimulus();
    rand_stall = 1'b0;
    for (int a = 0; a < 256; a += 64) checkRead("final_sweep", 24'(a), 64);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
